// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - 256-bit cache line <-> 4 x 64-bit memory burst adaptor
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   line_i / line_o       writeback line from cache / assembled fill line to cache
//   address_i, read_i,    cache line address and request strobes (held until resp_o)
//   write_i, resp_o       resp_o is a one-cycle completion pulse
//   burst_i / burst_o     64-bit read beat from memory / write beat to memory
//   address_o             32-byte aligned burst address to memory
//   read_o, write_o       memory burst request
//   resp_i                memory beat strobe, one beat per high cycle
module cacheline_adaptor (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] line_i,
    output logic [255:0] line_o,
    input  logic [31:0]  address_i,
    input  logic         read_i,
    input  logic         write_i,
    output logic         resp_o,
    input  logic [63:0]  burst_i,
    output logic [63:0]  burst_o,
    output logic [31:0]  address_o,
    output logic         read_o,
    output logic         write_o,
    input  logic         resp_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [255:0]  buf_q, buf_d;
    logic [255:0]  line_q, line_d;
    logic [31:0]   addr_q, addr_d;
    logic [7:0]    beat_base;

    // Bit offset of the current beat within the line.
    assign beat_base = {cnt_q, 6'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            buf_q   <= '0;
            line_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        line_d  = line_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                // Writeback wins when both requests are present; the fill
                // request stays asserted and is taken after DONE.
                if (write_i) begin
                    buf_d   = line_i;
                    addr_d  = address_i & 32'hFFFF_FFE0;
                    cnt_d   = 2'd0;
                    state_d = WR;
                end else if (read_i) begin
                    addr_d  = address_i & 32'hFFFF_FFE0;
                    cnt_d   = 2'd0;
                    state_d = RD;
                end
            end
            RD: begin
                if (resp_i) begin
                    line_d[beat_base +: 64] = burst_i;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = DONE;
                    end
                end
            end
            WR: begin
                if (resp_i) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        read_o  = (state_q == RD);
        write_o = (state_q == WR);
        resp_o  = (state_q == DONE);
    end

    assign address_o = addr_q;
    assign line_o    = line_q;
    // Write beat follows the counter directly so it is valid in the same
    // cycle memory strobes it.
    assign burst_o   = buf_q[beat_base +: 64];

endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Converts between the cache's 256-bit line transfers and the 64-bit, 4-beat burst protocol of physical memory. Sits directly downstream of the cache datapath/controller. It accepts one line read (fill) or line write (writeback) at a time, sequences four 64-bit beats to or from memory, and returns a single-cycle response to the cache.

## Interface
Parameters: none (line = 256 bits, beat = 64 bits, 4 beats per burst are fixed).

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- line_i  input  256  line to write back, from cache pmem_wdata
- line_o  output  256  assembled fill line, to cache pmem_rdata
- address_i  input  32  line address from cache pmem_address
- read_i  input  1  cache requests line fill; held until resp_o
- write_i  input  1  cache requests writeback; held until resp_o
- resp_o  output  1  one-cycle completion pulse to cache
- burst_i  input  64  read beat from memory
- burst_o  output  64  write beat to memory
- address_o  output  32  burst address to memory
- read_o  output  1  memory read request
- write_o  output  1  memory write request
- resp_i  input  1  memory beat strobe; one beat per high cycle

## Operation
- States: IDLE, RD, WR, DONE. Beat counter cnt (2 bits).
- IDLE: if write_i, latch line_i into a 256-bit buffer and {address_i[31:5],5'b0} into address_o, cnt=0, go WR. Else if read_i, latch address the same way, cnt=0, go RD. write_i has priority when both are high.
- RD: read_o=1. Each cycle resp_i=1: line_o[64*cnt +: 64] <= burst_i, cnt++. On the beat with cnt==3, go DONE.
- WR: write_o=1, burst_o = buffer[64*cnt +: 64] (combinational from cnt). Each cycle resp_i=1: cnt++. On the beat with cnt==3, go DONE.
- DONE: resp_o=1 for exactly one cycle. read_o and write_o are 0. Go IDLE.
- resp_o, read_o and write_o are Moore outputs decoded from state.
- Gaps are allowed: resp_i=0 mid-burst holds cnt and state. The request stays asserted.
- resp_i in IDLE or DONE is ignored. Changes to read_i, write_i, line_i or address_i while busy are ignored, because inputs are latched at accept.
- line_o holds its value after DONE until the next fill overwrites it. A writeback does not modify line_o.
- Counter wraps 3->0 at the end of each burst. No partial bursts.

## Timing
- Reset values: state=IDLE, cnt=0, resp_o=0, read_o=0, write_o=0, address_o=0, line_o=0, burst_o=0 (buffer cleared).
- Reset mid-burst aborts the transfer at the next edge: outputs return to reset values and no resp_o is produced. Memory must tolerate the dropped request.
- Request sampled at edge t. read_o or write_o is high from cycle t+1.
- Best-case fill (resp_i high cycles t+1..t+4):
  - last beat captured at edge ending t+4
  - resp_o high in cycle t+5, with line_o valid in that cycle
  - IDLE in t+6
- Minimum request-to-resp latency is 5 cycles; each resp_i gap adds one cycle.
- Cache must drop read_i/write_i by the cycle after resp_o. A request still high in IDLE is treated as new.
- Back-to-back: writeback then fill gives the next accept in the cycle after DONE. The minimum period is 6 cycles per line.

## Test plan
- Reset: assert rst 2 cycles during an active RD burst, then release -> all outputs 0, state IDLE, no resp_o. A following read works normally.
- Fill, no gaps: address_i=0x1234_5678, read_i held. Memory returns beats 0x...00 to 0x...03 on 4 consecutive cycles -> address_o=0x1234_5660, read_o high 4 cycles, resp_o single pulse on the 5th cycle after accept, line_o={beat3,beat2,beat1,beat0}.
- Writeback with gaps: line_i=256'h0123...cdef (distinct per beat). resp_i pattern 1,0,0,1,1,0,1 -> burst_o steps through line_i[63:0] to line_i[255:192] only on resp_i-high cycles. write_o drops after the 4th beat, then a one-cycle resp_o.
- Simultaneous read_i and write_i in IDLE -> write burst occurs first with write_o=1 and read_o=0. With read_i still held, a fill follows after DONE.
- Input change mid-burst: alter address_i and line_i during WR -> address_o and burst_o data unchanged from the latched values.
- Spurious resp_i in IDLE for 3 cycles, then a read -> cnt starts at 0, line_o beat order is correct, no extra resp_o.
